tdc_hit_sequencer: RTL and testbench
====================================

# tdc_hit_sequencer

Controller that sequences one TDC measurement: arms on request, waits for a hit, latches the coarse counter, strobes the thermometer-code capture register, waits for the ones-count result, and emits one timestamp record over a valid/ready handshake. It sits between the TDC front end (delay line plus capture register plus ones-counter) and the readout FIFO. It owns the free-running coarse counter and the capture strobe. The ones-counter remains a separate datapath block.

## Interface
Parameters:
- FINE_W, 8: width of the fine count from the ones-counter.
- COARSE_W, 16: coarse counter width.
- CNT_LAT, 2: cycles from the `code_latch` cycle to `fine_count` being valid, range 1–7.
- TIMEOUT, 1023: ARMED cycles before a timeout record is emitted; ≥1.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `arm`, in, 1: start request, sampled in IDLE only.
- `auto_rearm`, in, 1: after a record is accepted, return to ARMED instead of IDLE.
- `hit_det`, in, 1: synchronized hit strobe from the front end.
- `code_latch`, out, 1: one-cycle load enable for the thermometer-code capture register.
- `fine_count`, in, FINE_W: ones-count result.
- `ts_valid`, out, 1: record valid.
- `ts_ready`, in, 1: downstream accept.
- `ts_data`, out, COARSE_W+FINE_W: record data, `{coarse, fine}`.
- `ts_timeout`, out, 1: record flag, 1 = no hit occurred before timeout.
- `busy`, out, 1: state ≠ IDLE.
- `miss_cnt`, out, 8: saturating count of hits ignored because the sequencer was not ARMED.

## Operation
- **States:** IDLE, ARMED, LATCH, WAIT, OUT.
- **IDLE:**
  - `arm` = 1 → ARMED.
  - `hit_det` is ignored here and increments `miss_cnt`.
- **ARMED:**
  - `hit_det` = 1 → store the current coarse counter value in the coarse field, then → LATCH.
  - Timeout counter reaching TIMEOUT−1 with no hit → OUT with `ts_timeout` = 1 and `ts_data` = 0.
- **LATCH:** `code_latch` = 1 for exactly this cycle. → WAIT, with the wait counter loaded to CNT_LAT−1.
- **WAIT:**
  - Count down.
  - At 0, sample `fine_count` into the fine field and set `ts_timeout` = 0. → OUT.
- **OUT:**
  - `ts_valid` = 1, and `ts_data`/`ts_timeout` are held stable until `ts_valid && ts_ready`.
  - On accept: `auto_rearm` ? ARMED : IDLE.
- **Coarse counter:** free-running, increments every cycle, wraps from 2^COARSE_W−1 to 0 with no flag.
- **`miss_cnt`:** increments on `hit_det` in any state other than ARMED. Saturates at 255 and clears only on reset.
- **`arm` outside IDLE:** ignored, with no queuing.
- **Timeout counter:** cleared on every entry to ARMED.
- **`hit_det` in the same cycle as timeout expiry:** the hit wins and the sequencer goes → LATCH.

## Timing
- **Reset values:**
  - State = IDLE.
  - `code_latch`, `ts_valid`, `ts_timeout`, `busy` = 0.
  - `ts_data` = 0, `miss_cnt` = 0, coarse counter = 0.
- **Reset mid-operation:** immediate return to IDLE. Any pending record is dropped.
- **`arm` to ARMED:** `arm` high in cycle 0 → ARMED in cycle 1, and `busy` = 1 from cycle 1.
- **Hit sequence:** `hit_det` high in ARMED at cycle N:
  - Coarse field = counter value of cycle N.
  - `code_latch` high in cycle N+1.
  - `fine_count` sampled at the end of cycle N+1+CNT_LAT.
  - `ts_valid` high from cycle N+2+CNT_LAT.
- **Accept:** `ts_ready` high with `ts_valid` in cycle M → `ts_valid` low in M+1, and the state is ARMED/IDLE in M+1.
- **Back-to-back hits:** minimum hit-to-hit spacing under `auto_rearm` with `ts_ready` tied high is CNT_LAT+3 cycles.
- **All outputs are registered.**

## Configuration
- **`TDC_TIMEOUT_EN` defined:**
  - ARMED timeout logic is present as described above.
  - `ts_timeout` can be 1.
- **`TDC_TIMEOUT_EN` undefined:**
  - No timeout counter; ARMED waits indefinitely.
  - `ts_timeout` is tied to 0.
  - The TIMEOUT parameter is unused.

## Test plan
- **Basic hit:** CNT_LAT=2. Reset, `arm` at cycle 0, `hit_det` at cycle 10 with coarse = 10, `fine_count` = 37 at cycle 13, `ts_ready` = 1 → `code_latch` only in cycle 11, `ts_valid` in cycle 14, `ts_data` = {16'd10, 8'd37}, then IDLE.
- **Backpressure:** `ts_ready` = 0 for 20 cycles while `hit_det`/`fine_count` toggle → `ts_data` stable and `ts_valid` held throughout; a single accept yields exactly one record.
- **Timeout:** `TDC_TIMEOUT_EN` defined, TIMEOUT = 8. `arm`, no hit → `ts_valid` with `ts_timeout` = 1 and `ts_data` = 0 exactly 8 cycles after ARMED entry. `hit_det` on the expiry cycle → normal record instead.
- **Misses:** 300 `hit_det` pulses while IDLE → `miss_cnt` = 255, with no `code_latch` and no `ts_valid`.
- **Auto-rearm and wrap:** COARSE_W = 4, `auto_rearm` = 1, hits every CNT_LAT+3 cycles across a counter wrap → every hit is recorded, and the coarse field wraps from 15 to 0.
- **Reset mid-operation:** assert `rst_n` = 0 during WAIT → all outputs return to reset values immediately, and no record appears after release.

Source files
------------

// File: rtl/tdc_hit_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : tdc_hit_sequencer
// Brief    : Sequences one TDC measurement (arm, hit, capture strobe, fine-count
//            wait) and emits a {coarse, fine} timestamp record over valid/ready.
//            Optional macro TDC_TIMEOUT_EN adds the ARMED timeout record.
// Revision : 1.0
//==============================================================================
module tdc_hit_sequencer #(
    parameter int FINE_W   = 8,
    parameter int COARSE_W = 16,
    parameter int CNT_LAT  = 2,
    parameter int TIMEOUT  = 1023
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         arm,
    input  logic                         auto_rearm,
    input  logic                         hit_det,
    output logic                         code_latch,
    input  logic [FINE_W-1:0]            fine_count,
    output logic                         ts_valid,
    input  logic                         ts_ready,
    output logic [COARSE_W+FINE_W-1:0]   ts_data,
    output logic                         ts_timeout,
    output logic                         busy,
    output logic [7:0]                   miss_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_LATCH = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    localparam logic [2:0] c_WAIT_LOAD = 3'(CNT_LAT - 1);

    if (CNT_LAT < 1 || CNT_LAT > 7) begin : g_cnt_lat_range
        $error("tdc_hit_sequencer: CNT_LAT must be within 1..7");
    end

    if (TIMEOUT < 1) begin : g_timeout_range
        $error("tdc_hit_sequencer: TIMEOUT must be at least 1");
    end

    state_t                r_state;
    logic [COARSE_W-1:0]   r_coarse;
    logic [COARSE_W-1:0]   r_coarse_hit;
    logic [2:0]            r_wait;
    logic                  w_tmo_expire;

`ifdef TDC_TIMEOUT_EN
    localparam int c_TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

    logic [c_TMO_W-1:0] r_tmo;

    assign w_tmo_expire = (r_state == S_ARMED) && (r_tmo == c_TMO_LAST);

    // Held at zero outside ARMED, so every entry into ARMED starts a fresh count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo <= '0;
        end else if (r_state != S_ARMED) begin
            r_tmo <= '0;
        end else if (!w_tmo_expire) begin
            r_tmo <= r_tmo + c_TMO_W'(1);
        end
    end
`else
    assign w_tmo_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coarse <= '0;
        end else begin
            r_coarse <= r_coarse + COARSE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_cnt <= '0;
        end else if (hit_det && (r_state != S_ARMED) && (miss_cnt != 8'hFF)) begin
            miss_cnt <= miss_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_coarse_hit <= '0;
            r_wait       <= '0;
            code_latch   <= 1'b0;
            ts_valid     <= 1'b0;
            ts_timeout   <= 1'b0;
            ts_data      <= '0;
            busy         <= 1'b0;
        end else begin
            code_latch <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (arm) begin
                        r_state <= S_ARMED;
                        busy    <= 1'b1;
                    end
                end
                S_ARMED: begin
                    // A hit on the expiry cycle takes priority over the timeout.
                    if (hit_det) begin
                        r_coarse_hit <= r_coarse;
                        code_latch   <= 1'b1;
                        r_state      <= S_LATCH;
                    end else if (w_tmo_expire) begin
                        ts_data    <= '0;
                        ts_timeout <= 1'b1;
                        ts_valid   <= 1'b1;
                        r_state    <= S_OUT;
                    end
                end
                S_LATCH: begin
                    r_wait  <= c_WAIT_LOAD;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait == 3'd0) begin
                        ts_data    <= {r_coarse_hit, fine_count};
                        ts_timeout <= 1'b0;
                        ts_valid   <= 1'b1;
                        r_state    <= S_OUT;
                    end else begin
                        r_wait <= r_wait - 3'd1;
                    end
                end
                S_OUT: begin
                    if (ts_ready) begin
                        ts_valid <= 1'b0;
                        if (auto_rearm) begin
                            r_state <= S_ARMED;
                        end else begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    ts_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tdc_hit_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : tb_tdc_hit_sequencer
// Brief    : Self-checking bench; timestamp-based reference model plus directed
//            and random stimulus. Honors TDC_TIMEOUT_EN like the design.
// Revision : 1.0
//==============================================================================
module tb_tdc_hit_sequencer;

    localparam int FW  = 8;
    localparam int CW  = 8;
    localparam int LAT = 2;
    localparam int TMO = 8;
`ifdef TDC_TIMEOUT_EN
    localparam int BHIT = 7;
`else
    localparam int BHIT = 10;
`endif

    logic            clk        = 1'b0;
    logic            rst_n      = 1'b0;
    logic            arm        = 1'b0;
    logic            auto_rearm = 1'b0;
    logic            hit_det    = 1'b0;
    logic            ts_ready   = 1'b0;
    logic [FW-1:0]   fine_count = '0;
    logic            code_latch;
    logic            ts_valid;
    logic            ts_timeout;
    logic            busy;
    logic [CW+FW-1:0] ts_data;
    logic [7:0]      miss_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tdc_hit_sequencer #(
        .FINE_W   (FW),
        .COARSE_W (CW),
        .CNT_LAT  (LAT),
        .TIMEOUT  (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .arm        (arm),
        .auto_rearm (auto_rearm),
        .hit_det    (hit_det),
        .code_latch (code_latch),
        .fine_count (fine_count),
        .ts_valid   (ts_valid),
        .ts_ready   (ts_ready),
        .ts_data    (ts_data),
        .ts_timeout (ts_timeout),
        .busy       (busy),
        .miss_cnt   (miss_cnt)
    );

    // Reference model: cycle index since reset release, plus event timestamps.
    int               cyc;
    bit               m_busy, m_armed, m_out, m_to;
    int               m_hit_at, m_armed_at, m_miss;
    logic [CW-1:0]    m_coarse;
    logic [CW+FW-1:0] m_data;
    int               rec_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] rnd();
        return FW'($urandom);
    endfunction

    task automatic model_reset();
        cyc        = 0;
        m_busy     = 1'b0;
        m_armed    = 1'b0;
        m_out      = 1'b0;
        m_to       = 1'b0;
        m_hit_at   = -1;
        m_armed_at = 0;
        m_miss     = 0;
        m_coarse   = '0;
        m_data     = '0;
    endtask

    task automatic compare();
        check("busy", busy, m_busy);
        check("code_latch", code_latch, (m_hit_at >= 0 && cyc == m_hit_at + 1));
        check("ts_valid", ts_valid, m_out);
        if (m_out) begin
            check("ts_data", ts_data, m_data);
            check("ts_timeout", ts_timeout, m_to);
        end
        check("miss_cnt", miss_cnt, m_miss);
    endtask

    task automatic advance(input bit a, input bit ar, input bit h, input logic [FW-1:0] f, input bit r);
        if (h && !m_armed && m_miss < 255) m_miss++;
        if (!m_busy) begin
            if (a) begin
                m_busy     = 1'b1;
                m_armed    = 1'b1;
                m_armed_at = cyc + 1;
            end
        end else if (m_armed) begin
            if (h) begin
                m_hit_at = cyc;
                m_coarse = cyc[CW-1:0];
                m_armed  = 1'b0;
            end
`ifdef TDC_TIMEOUT_EN
            else if ((cyc - m_armed_at) == TMO - 1) begin
                m_armed = 1'b0;
                m_out   = 1'b1;
                m_to    = 1'b1;
                m_data  = '0;
            end
`endif
        end else if (m_out) begin
            if (r) begin
                m_out    = 1'b0;
                m_hit_at = -1;
                if (ar) begin
                    m_armed    = 1'b1;
                    m_armed_at = cyc + 1;
                end else begin
                    m_busy = 1'b0;
                end
            end
        end else if (cyc == m_hit_at + 1 + LAT) begin
            m_out  = 1'b1;
            m_to   = 1'b0;
            m_data = {m_coarse, f};
        end
    endtask

    // Called at a falling edge: check this cycle, drive its inputs, move to next.
    task automatic step(input bit a, input bit ar, input bit h, input logic [FW-1:0] f, input bit r);
        compare();
        arm        = a;
        auto_rearm = ar;
        hit_det    = h;
        fine_count = f;
        ts_ready   = r;
        if (ts_valid && r) rec_cnt++;
        advance(a, ar, h, f, r);
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_code_latch"}, code_latch, 0);
        check({tag, "_ts_valid"}, ts_valid, 0);
        check({tag, "_ts_timeout"}, ts_timeout, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ts_data"}, ts_data, 0);
        check({tag, "_miss_cnt"}, miss_cnt, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        arm        = 1'b0;
        auto_rearm = 1'b0;
        hit_det    = 1'b0;
        ts_ready   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int recs;
        int hits;
        model_reset();

        // Basic hit: arm at 0, hit at BHIT, fine=37 sampled at BHIT+3.
        do_reset();
        step(1'b1, 1'b0, 1'b0, rnd(), 1'b1);
        while (cyc < BHIT) step(1'b0, 1'b0, 1'b0, rnd(), 1'b1);
        step(1'b0, 1'b0, 1'b1, rnd(), 1'b1);
        check("basic_latch", code_latch, 1);
        step(1'b0, 1'b0, 1'b0, rnd(), 1'b1);
        check("basic_latch_once", code_latch, 0);
        step(1'b0, 1'b0, 1'b0, rnd(), 1'b1);
        check("basic_not_valid_yet", ts_valid, 0);
        step(1'b0, 1'b0, 1'b0, 8'd37, 1'b1);
        check("basic_valid", ts_valid, 1);
        check("basic_data", ts_data, {8'(BHIT), 8'd37});
        step(1'b0, 1'b0, 1'b0, rnd(), 1'b1);
        check("basic_idle", busy, 0);
        check("basic_valid_drop", ts_valid, 0);

        // Backpressure: record {3, C3} must hold for 20 stalled cycles.
        do_reset();
        step(1'b1, 1'b0, 1'b0, rnd(), 1'b0);
        step(1'b0, 1'b0, 1'b0, rnd(), 1'b0);
        step(1'b0, 1'b0, 1'b0, rnd(), 1'b0);
        step(1'b0, 1'b0, 1'b1, rnd(), 1'b0);
        step(1'b0, 1'b0, 1'b0, rnd(), 1'b0);
        step(1'b0, 1'b0, 1'b0, rnd(), 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'hC3, 1'b0);
        recs = rec_cnt;
        for (int i = 0; i < 20; i++) begin
            check("bp_valid", ts_valid, 1);
            check("bp_data", ts_data, 16'h03C3);
            step(1'b0, 1'b0, 1'($urandom_range(0, 1)), rnd(), 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, rnd(), 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, rnd(), 1'b1);
        check("bp_records", rec_cnt - recs, 1);

`ifdef TDC_TIMEOUT_EN
        // Timeout: ARMED from cycle 1, timeout record visible at cycle 1+TMO.
        do_reset();
        step(1'b1, 1'b1, 1'b0, rnd(), 1'b0);
        while (cyc < 1 + TMO) begin
            check("to_no_valid", ts_valid, 0);
            step(1'b0, 1'b1, 1'b0, rnd(), 1'b0);
        end
        check("to_valid", ts_valid, 1);
        check("to_flag", ts_timeout, 1);
        check("to_data", ts_data, 0);
        step(1'b0, 1'b1, 1'b0, rnd(), 1'b1);
        // Re-armed at 10; hit lands on the expiry cycle 10+TMO-1.
        while (cyc < 10 + TMO - 1) step(1'b0, 1'b0, 1'b0, rnd(), 1'b0);
        step(1'b0, 1'b0, 1'b1, rnd(), 1'b0);
        while (cyc < 10 + TMO - 1 + 2 + LAT) step(1'b0, 1'b0, 1'b0, rnd(), 1'b0);
        check("to_hit_valid", ts_valid, 1);
        check("to_hit_flag", ts_timeout, 0);
        check("to_hit_coarse", ts_data[15:8], 10 + TMO - 1);
        step(1'b0, 1'b0, 1'b0, rnd(), 1'b1);
`endif

        // Misses: 300 pulses in IDLE saturate the counter at 255.
        do_reset();
        for (int i = 0; i < 600; i++) step(1'b0, 1'b0, 1'(i % 2 == 0), rnd(), 1'b1);
        check("miss_sat", miss_cnt, 255);
        check("miss_busy", busy, 0);

        // Auto-rearm with hits every LAT+3 cycles across the coarse wrap.
        do_reset();
        recs = rec_cnt;
        hits = 0;
        while (cyc < 270) begin
            if (cyc == 259) check("wrap_hi", ts_data[15:8], 255);
            if (cyc == 264) check("wrap_lo", ts_data[15:8], 4);
            if (cyc > 0 && cyc % (LAT + 3) == 0) hits++;
            step(1'(cyc == 0), 1'b1, 1'(cyc > 0 && cyc % (LAT + 3) == 0), rnd(), 1'b1);
        end
        check("wrap_records", rec_cnt - recs, hits);

        // Reset during WAIT: outputs clear at once, nothing emitted afterwards.
        do_reset();
        step(1'b1, 1'b0, 1'b1, rnd(), 1'b1);
        step(1'b0, 1'b0, 1'b0, rnd(), 1'b1);
        step(1'b0, 1'b0, 1'b0, rnd(), 1'b1);
        step(1'b0, 1'b0, 1'b1, rnd(), 1'b1);
        step(1'b0, 1'b0, 1'b0, rnd(), 1'b1);
        check("mid_busy", busy, 1);
        check("mid_miss", miss_cnt, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("mid");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        recs = rec_cnt;
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, rnd(), 1'b1);
        check("mid_no_record", rec_cnt - recs, 0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 5) == 0), rnd(), 1'($urandom_range(0, 2) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
